// File: rtl/reg_file_param_if.sv
// ---------------------------------------------------------------------------
// reg_file_param_if
// Bundles the register file's read, write, maintenance and dump signals.
//   master : the datapath or debug host. It drives addresses, write data,
//            requests and dump_ready. It receives read data and dump beats.
//   slave  : the register file itself.
// Signals:
//   read_reg1/2, read_data1/2   two combinational read ports
//   write_reg, reg_write,       one synchronous write port
//   write_data
//   clear_req, dump_req         maintenance requests, one-cycle pulses
//   busy                        sequencer is not idle
//   dump_valid/ready,           register dump stream
//   dump_addr/data
// ---------------------------------------------------------------------------
interface reg_file_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [ADDR_W-1:0] write_reg;
    logic              reg_write;
    logic [DATA_W-1:0] write_data;
    logic              clear_req;
    logic              dump_req;
    logic              busy;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;

    modport master (
        output read_reg1, read_reg2, write_reg, reg_write, write_data,
               clear_req, dump_req, dump_ready,
        input  read_data1, read_data2, busy, dump_valid, dump_addr, dump_data
    );

    modport slave (
        input  read_reg1, read_reg2, write_reg, reg_write, write_data,
               clear_req, dump_req, dump_ready,
        output read_data1, read_data2, busy, dump_valid, dump_addr, dump_data
    );
endinterface

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
// General-purpose register file for the MIPS datapath. It has DEPTH = 2**ADDR_W
// registers of DATA_W bits, two combinational read ports and one synchronous
// write port. Two features are optional: same-cycle write-to-read bypass, and
// a hard-wired zero register.
// A small sequencer handles maintenance:
//   CLEAR : writes 0 into every register, one register per cycle. It runs
//           after reset and on clear_req.
//   DUMP  : streams every register out over dump_valid/dump_ready.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous, active-low reset. It forces the sequencer into CLEAR.
//   bus    reg_file_param_if.slave, which carries the read, write and dump
//          signals
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_file_param_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DUMP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nx;
    logic [DATA_W-1:0] r_regs [DEPTH];

    logic w_ptr_last;
    logic w_in_clear;
    logic w_wr_en;
    logic w_force_zero;
    logic w_dump_valid;

    // Reads the array as it was last stored. This path has no bypass, and
    // register 0 reads as zero when ZERO_REG is set.
    function automatic logic [DATA_W-1:0] f_stored(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] regval
    );
        if (ZERO_REG && (addr == '0))
            return '0;
        return regval;
    endfunction

    // Architectural read. The zero-register rule is checked before bypass.
    function automatic logic [DATA_W-1:0] f_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] regval,
        input logic              wr,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (ZERO_REG && (addr == '0))
            return '0;
        if (BYPASS && wr && (waddr == addr))
            return wdata;
        return regval;
    endfunction

    assign w_ptr_last = (r_ptr == {ADDR_W{1'b1}});
    assign w_in_clear = (r_state == CLEAR);

    // Normal writes are blocked in two cases: during reset and during the
    // clear sweep. This stops a stale write from landing after a register
    // has already been zeroed.
    assign w_wr_en = rst_n && bus.reg_write && !w_in_clear &&
                     !(ZERO_REG && (bus.write_reg == '0));

    // The visible outputs are also gated by rst_n. This keeps them at
    // defined values while reset is held, even before the first edge has
    // loaded the state register.
    assign w_force_zero = !rst_n || w_in_clear;
    assign w_dump_valid = rst_n && (r_state == DUMP);

    // -------------------------------------------------------------------
    // Sequencer: state register
    // -------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

    // -------------------------------------------------------------------
    // Sequencer: next state
    // -------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        case (r_state)
            IDLE: begin
                // clear_req has priority when both requests arrive together.
                if (bus.clear_req) begin
                    w_state_nx = CLEAR;
                    w_ptr_nx   = '0;
                end else if (bus.dump_req) begin
                    w_state_nx = DUMP;
                    w_ptr_nx   = '0;
                end
            end
            CLEAR: begin
                if (w_ptr_last) begin
                    w_state_nx = IDLE;
                    w_ptr_nx   = '0;
                end else begin
                    w_ptr_nx = r_ptr + 1'b1;
                end
            end
            DUMP: begin
                // clear_req aborts the dump, even in a cycle where the
                // current beat is being accepted.
                if (bus.clear_req) begin
                    w_state_nx = CLEAR;
                    w_ptr_nx   = '0;
                end else if (bus.dump_ready) begin
                    if (w_ptr_last) begin
                        w_state_nx = IDLE;
                        w_ptr_nx   = '0;
                    end else begin
                        w_ptr_nx = r_ptr + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_ptr_nx   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------
    // Register array. Its contents are never reset directly; the clear
    // sweep zeroes them instead.
    // -------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && w_in_clear)
            r_regs[r_ptr] <= '0;
        else if (w_wr_en)
            r_regs[bus.write_reg] <= bus.write_data;
    end

    // -------------------------------------------------------------------
    // Read ports and dump stream
    // -------------------------------------------------------------------
    assign bus.read_data1 = w_force_zero ? '0 :
        f_read(bus.read_reg1, r_regs[bus.read_reg1], bus.reg_write,
               bus.write_reg, bus.write_data);
    assign bus.read_data2 = w_force_zero ? '0 :
        f_read(bus.read_reg2, r_regs[bus.read_reg2], bus.reg_write,
               bus.write_reg, bus.write_data);

    assign bus.busy       = !rst_n || (r_state != IDLE);
    assign bus.dump_valid = w_dump_valid;
    assign bus.dump_addr  = w_dump_valid ? r_ptr : '0;
    // A beat carries the stored value. A write to the same register in the
    // same cycle only affects later beats.
    assign bus.dump_data  = w_dump_valid ? f_stored(r_ptr, r_regs[r_ptr]) : '0;

endmodule
